// File: rtl/common_types_pkg.sv
// Shared types and encodings for the MEM stage.
//   word_t        32-bit data/address word
//   reg_t         5-bit register index
//   mem_state_t   data-bus access FSM state
//   PC_*          em_pc_ctrl encodings
//   WR_SRC_*      em_reg_wr_src encodings
//   DW_*          em_dwrite store-size encodings
package common_types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  reg_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  localparam logic [1:0] PC_INC    = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JAL    = 2'd2;
  localparam logic [1:0] PC_JALR   = 2'd3;

  localparam logic [1:0] WR_SRC_ALU  = 2'd0;
  localparam logic [1:0] WR_SRC_LOAD = 2'd1;
  localparam logic [1:0] WR_SRC_PC4  = 2'd2;

  localparam logic [1:0] DW_NONE = 2'd0;
  localparam logic [1:0] DW_BYTE = 2'd1;
  localparam logic [1:0] DW_HALF = 2'd2;
  localparam logic [1:0] DW_WORD = 2'd3;

  function automatic word_t word_addr(input word_t a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/memory_stage_store_align.sv
// Store lane alignment and misalignment detection (combinational).
//   size      access size (DW_* encoding; loads are presented as DW_WORD)
//   addr_lo   address bits [1:0]
//   rdat2     raw store data
//   strb      byte strobes for the addressed lanes
//   wdata     store data replicated across lanes
//   misalign  half on odd address, or word not 4-byte aligned
module store_align
  import common_types_pkg::*;
(
  input  logic [1:0] size,
  input  logic [1:0] addr_lo,
  input  word_t      rdat2,
  output logic [3:0] strb,
  output word_t      wdata,
  output logic       misalign
);

  always_comb begin
    strb     = 4'b0000;
    wdata    = rdat2;
    misalign = 1'b0;
    case (size)
      DW_BYTE: begin
        strb  = 4'b0001 << addr_lo;
        wdata = {4{rdat2[7:0]}};
      end
      DW_HALF: begin
        strb     = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata    = {2{rdat2[15:0]}};
        misalign = addr_lo[0];
      end
      DW_WORD: begin
        strb     = 4'b1111;
        misalign = (addr_lo != 2'b00);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// MEM stage of the 5-stage RV32I pipeline.
// Performs the data-bus access for the instruction in the EX/MEM latch,
// resolves branches/jumps against the fetch prediction and drives the
// registered MEM/WB latch.
//   CLK, nRST                 clock (rising edge), async active-low reset
//   em_*                      EX/MEM latch fields
//   wb_en                     MEM/WB latch enable from downstream
//   dmem_*                    data-bus request/response
//   mem_stall                 hold EX/MEM and upstream
//   redirect, redirect_pc     misprediction flush and corrected next PC
//   misalign                  access suppressed this cycle
//   wb_valid/halt/rd/wdata    registered MEM/WB latch
module memory_stage
  import common_types_pkg::*;
#(
  parameter word_t RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        em_valid,
  input  word_t       em_pc,
  input  logic        em_halt,
  input  reg_t        em_rd,
  input  logic        em_dread,
  input  logic [1:0]  em_dwrite,
  input  logic [1:0]  em_reg_wr_src,
  input  logic        em_branch_pol,
  input  logic [1:0]  em_pc_ctrl,
  input  word_t       em_rdat2,
  input  word_t       em_alu_out,
  input  logic        em_alu_zero,
  input  word_t       em_pc_plus_imm,
  input  logic        em_branch_predict,
  input  word_t       em_branch_target,
  input  logic        wb_en,
  output logic        dmem_ren,
  output logic        dmem_wen,
  output word_t       dmem_addr,
  output word_t       dmem_wdata,
  output logic [3:0]  dmem_strb,
  input  logic        dmem_ready,
  input  word_t       dmem_rdata,
  output logic        mem_stall,
  output logic        redirect,
  output word_t       redirect_pc,
  output logic        misalign,
  output logic        wb_valid,
  output logic        wb_halt,
  output reg_t        wb_rd,
  output word_t       wb_wdata
);

  mem_state_t state;
  word_t      rdata_q;

  logic [1:0] acc_size;
  logic [3:0] al_strb;
  word_t      al_wdata;
  logic       al_misalign;

  logic       is_mem;
  logic       access;
  logic       req;
  word_t      load_data;
  word_t      wb_data_next;
  word_t      pc_plus4;
  logic       taken;
  word_t      target;
  word_t      next_pc;
  logic       mispredict;

  // Loads are word-only, so they reuse the word alignment rule.
  assign acc_size = (em_dwrite != DW_NONE) ? em_dwrite :
                    (em_dread ? DW_WORD : DW_NONE);

  store_align u_store_align (
    .size     (acc_size),
    .addr_lo  (em_alu_out[1:0]),
    .rdat2    (em_rdat2),
    .strb     (al_strb),
    .wdata    (al_wdata),
    .misalign (al_misalign)
  );

  // Reset gates the combinational request path so a request in flight
  // drops the moment nRST falls rather than at the next edge.
  // A latched halt blocks every further bus request.
  assign is_mem   = em_dread | (em_dwrite != DW_NONE);
  assign misalign = nRST & em_valid & is_mem & al_misalign;
  assign access   = nRST & em_valid & is_mem & ~al_misalign & ~wb_halt;
  assign req      = access & (state != DONE);

  assign dmem_ren   = req & em_dread;
  assign dmem_wen   = req & (em_dwrite != DW_NONE);
  assign dmem_addr  = word_addr(em_alu_out);
  assign dmem_wdata = al_wdata;
  assign dmem_strb  = dmem_wen ? al_strb : 4'b0000;

  assign mem_stall = access & (state != DONE) & ~dmem_ready;

  // A misaligned load never reaches the bus and writes back zero.
  always_comb begin
    load_data = (state == DONE) ? rdata_q : dmem_rdata;
    if (misalign) load_data = '0;
  end

  assign pc_plus4 = em_pc + 32'd4;

  always_comb begin
    wb_data_next = em_alu_out;
    case (em_reg_wr_src)
      WR_SRC_LOAD: wb_data_next = load_data;
      WR_SRC_PC4:  wb_data_next = pc_plus4;
      default:     wb_data_next = em_alu_out;
    endcase
  end

  assign taken  = ((em_pc_ctrl == PC_BRANCH) & (em_alu_zero ^ em_branch_pol)) |
                  (em_pc_ctrl >= PC_JAL);
  assign target = (em_pc_ctrl == PC_JALR) ? (em_alu_out & ~32'd1) : em_pc_plus_imm;
  assign next_pc = taken ? target : pc_plus4;

  assign mispredict = (taken != em_branch_predict) |
                      (taken & (target != em_branch_target));

  // Only fires on the cycle the instruction leaves the stage, so it is
  // naturally a single-cycle pulse per instruction.
  assign redirect    = nRST & em_valid & ~mem_stall & wb_en & mispredict;
  assign redirect_pc = nRST ? next_pc : RESET_PC;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      rdata_q  <= '0;
      wb_valid <= 1'b0;
      wb_halt  <= 1'b0;
      wb_rd    <= '0;
      wb_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (access && dmem_ready) begin
            rdata_q <= dmem_rdata;
            if (!wb_en) state <= DONE;
          end else if (access) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (dmem_ready) begin
            rdata_q <= dmem_rdata;
            state   <= wb_en ? IDLE : DONE;
          end
        end
        DONE: begin
          if (wb_en) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (wb_en) begin
        if (mem_stall) begin
          wb_valid <= 1'b0;
          wb_rd    <= '0;
          wb_wdata <= '0;
        end else begin
          wb_valid <= em_valid;
          wb_rd    <= em_valid ? em_rd : '0;
          wb_wdata <= wb_data_next;
          wb_halt  <= wb_halt | (em_valid & em_halt);
        end
      end
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
module tb_memory_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0200;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        em_valid;
  logic [31:0] em_pc;
  logic        em_halt;
  logic [4:0]  em_rd;
  logic        em_dread;
  logic [1:0]  em_dwrite;
  logic [1:0]  em_reg_wr_src;
  logic        em_branch_pol;
  logic [1:0]  em_pc_ctrl;
  logic [31:0] em_rdat2;
  logic [31:0] em_alu_out;
  logic        em_alu_zero;
  logic [31:0] em_pc_plus_imm;
  logic        em_branch_predict;
  logic [31:0] em_branch_target;
  logic        wb_en;
  logic        dmem_ren;
  logic        dmem_wen;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_strb;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        mem_stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        misalign;
  logic        wb_valid;
  logic        wb_halt;
  logic [4:0]  wb_rd;
  logic [31:0] wb_wdata;

  memory_stage #(.RESET_PC(RST_PC)) dut (
    .CLK(CLK), .nRST(nRST),
    .em_valid(em_valid), .em_pc(em_pc), .em_halt(em_halt), .em_rd(em_rd),
    .em_dread(em_dread), .em_dwrite(em_dwrite), .em_reg_wr_src(em_reg_wr_src),
    .em_branch_pol(em_branch_pol), .em_pc_ctrl(em_pc_ctrl), .em_rdat2(em_rdat2),
    .em_alu_out(em_alu_out), .em_alu_zero(em_alu_zero), .em_pc_plus_imm(em_pc_plus_imm),
    .em_branch_predict(em_branch_predict), .em_branch_target(em_branch_target),
    .wb_en(wb_en),
    .dmem_ren(dmem_ren), .dmem_wen(dmem_wen), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_strb(dmem_strb), .dmem_ready(dmem_ready),
    .dmem_rdata(dmem_rdata),
    .mem_stall(mem_stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .misalign(misalign),
    .wb_valid(wb_valid), .wb_halt(wb_halt), .wb_rd(wb_rd), .wb_wdata(wb_wdata)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [4:0] rd, input logic [31:0] data);
    exp_t e;
    e.rd   = rd;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic retire(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s observed=retire expected=scoreboard_entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_valid"}, {31'b0, wb_valid}, 32'd1);
      chk({tag, "_rd"},    {27'b0, wb_rd},    {27'b0, e.rd});
      chk({tag, "_wdata"}, wb_wdata,          e.data);
    end
  endtask

  // mode 0: expect bubble, 1: expect retirement, 2: no check
  task automatic step(input int mode, input string tag);
    @(posedge CLK);
    @(negedge CLK);
    if (mode == 1) retire(tag);
    else if (mode == 0) chk({tag, "_bubble"}, {31'b0, wb_valid}, 32'd0);
  endtask

  task automatic idle_inputs();
    em_valid = 0; em_pc = '0; em_halt = 0; em_rd = '0; em_dread = 0;
    em_dwrite = 2'd0; em_reg_wr_src = 2'd0; em_branch_pol = 0; em_pc_ctrl = 2'd0;
    em_rdat2 = '0; em_alu_out = '0; em_alu_zero = 0; em_pc_plus_imm = '0;
    em_branch_predict = 0; em_branch_target = '0; wb_en = 1; dmem_ready = 0;
    dmem_rdata = '0;
  endtask

  initial begin
    nRST = 1'b0;
    idle_inputs();
    #1;
    chk("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
    chk("rst_wb_wdata", wb_wdata, 32'd0);
    chk("rst_redirect_pc", redirect_pc, RST_PC);
    chk("rst_redirect", {31'b0, redirect}, 32'd0);
    @(negedge CLK);
    nRST = 1'b1;

    // zero-wait load
    em_valid = 1; em_dread = 1; em_rd = 5'd5; em_alu_out = 32'h100;
    em_reg_wr_src = 2'd1; em_pc = 32'h10; dmem_ready = 1; dmem_rdata = 32'hDEADBEEF;
    #1;
    chk("ld_ren", {31'b0, dmem_ren}, 32'd1);
    chk("ld_addr", dmem_addr, 32'h100);
    chk("ld_stall", {31'b0, mem_stall}, 32'd0);
    chk("ld_redirect", {31'b0, redirect}, 32'd0);
    push(5'd5, 32'hDEADBEEF);
    step(1, "ld");
    idle_inputs();
    step(0, "ld_after");

    // byte store, ready after 3 stall cycles
    em_valid = 1; em_dwrite = 2'd1; em_rdat2 = 32'h12345678; em_alu_out = 32'h203;
    em_pc = 32'h20;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("sb_stall", {31'b0, mem_stall}, 32'd1);
      chk("sb_wen", {31'b0, dmem_wen}, 32'd1);
      chk("sb_addr", dmem_addr, 32'h200);
      chk("sb_strb", {28'b0, dmem_strb}, 32'h8);
      chk("sb_wdata", dmem_wdata, 32'h78787878);
      step(0, "sb_wait");
    end
    dmem_ready = 1;
    #1;
    chk("sb_stall_end", {31'b0, mem_stall}, 32'd0);
    chk("sb_wen_end", {31'b0, dmem_wen}, 32'd1);
    push(5'd0, 32'h203);
    step(1, "sb");
    idle_inputs();

    // branch taken, predicted not taken
    em_valid = 1; em_pc_ctrl = 2'd1; em_alu_zero = 1; em_pc = 32'h40;
    em_pc_plus_imm = 32'h80; em_alu_out = 32'h0;
    #1;
    chk("br_redirect", {31'b0, redirect}, 32'd1);
    chk("br_redirect_pc", redirect_pc, 32'h80);
    em_branch_predict = 1; em_branch_target = 32'h80;
    #1;
    chk("br_pred_ok", {31'b0, redirect}, 32'd0);
    em_alu_zero = 0;
    #1;
    chk("br_nt_redirect", {31'b0, redirect}, 32'd1);
    chk("br_nt_pc", redirect_pc, 32'h44);
    push(5'd0, 32'h0);
    step(1, "br");
    idle_inputs();
    #1;
    chk("br_one_cycle", {31'b0, redirect}, 32'd0);

    // JALR, link value written back
    em_valid = 1; em_pc_ctrl = 2'd3; em_alu_out = 32'h1235; em_pc = 32'h300;
    em_reg_wr_src = 2'd2; em_rd = 5'd1;
    #1;
    chk("jalr_redirect", {31'b0, redirect}, 32'd1);
    chk("jalr_pc", redirect_pc, 32'h1234);
    push(5'd1, 32'h304);
    step(1, "jalr");
    idle_inputs();

    // load completes while downstream is blocked
    em_valid = 1; em_dread = 1; em_rd = 5'd7; em_alu_out = 32'h400;
    em_reg_wr_src = 2'd1; wb_en = 0; dmem_ready = 1; dmem_rdata = 32'hCAFEF00D;
    #1;
    chk("ldb_ren", {31'b0, dmem_ren}, 32'd1);
    chk("ldb_stall", {31'b0, mem_stall}, 32'd0);
    step(2, "ldb");
    dmem_ready = 0; dmem_rdata = 32'h11111111;
    #1;
    chk("ldb_done_ren", {31'b0, dmem_ren}, 32'd0);
    chk("ldb_done_stall", {31'b0, mem_stall}, 32'd0);
    chk("ldb_hold_rd", {27'b0, wb_rd}, 32'd1);
    step(2, "ldb2");
    chk("ldb_hold_rd2", {27'b0, wb_rd}, 32'd1);
    wb_en = 1;
    #1;
    chk("ldb_release_ren", {31'b0, dmem_ren}, 32'd0);
    push(5'd7, 32'hCAFEF00D);
    step(1, "ldb");
    idle_inputs();

    // misaligned word store and load
    em_valid = 1; em_dwrite = 2'd3; em_alu_out = 32'h102; em_rdat2 = 32'hAAAA5555;
    #1;
    chk("mis_flag", {31'b0, misalign}, 32'd1);
    chk("mis_wen", {31'b0, dmem_wen}, 32'd0);
    chk("mis_stall", {31'b0, mem_stall}, 32'd0);
    push(5'd0, 32'h102);
    step(1, "mis_st");
    idle_inputs();
    em_valid = 1; em_dread = 1; em_alu_out = 32'h101; em_rd = 5'd9;
    em_reg_wr_src = 2'd1; dmem_ready = 1; dmem_rdata = 32'hFFFFFFFF;
    #1;
    chk("mis_ld_ren", {31'b0, dmem_ren}, 32'd0);
    push(5'd9, 32'h0);
    step(1, "mis_ld");
    idle_inputs();

    // half store upper lane
    em_valid = 1; em_dwrite = 2'd2; em_alu_out = 32'h2A2; em_rdat2 = 32'h0000BEEF;
    dmem_ready = 1;
    #1;
    chk("sh_strb", {28'b0, dmem_strb}, 32'hC);
    chk("sh_wdata", dmem_wdata, 32'hBEEFBEEF);
    push(5'd0, 32'h2A2);
    step(1, "sh");
    idle_inputs();

    // reset during WAIT
    em_valid = 1; em_dread = 1; em_rd = 5'd3; em_alu_out = 32'h500; em_reg_wr_src = 2'd1;
    #1;
    chk("rw_stall", {31'b0, mem_stall}, 32'd1);
    step(0, "rw_wait");
    nRST = 0;
    #1;
    chk("rw_ren", {31'b0, dmem_ren}, 32'd0);
    chk("rw_wb_valid", {31'b0, wb_valid}, 32'd0);
    chk("rw_redirect_pc", redirect_pc, RST_PC);
    dmem_ready = 1; dmem_rdata = 32'h77777777;
    step(0, "rw_in_reset");
    idle_inputs();
    nRST = 1;
    step(0, "rw_after");

    // halt is sticky and blocks requests
    em_valid = 1; em_halt = 1;
    push(5'd0, 32'h0);
    step(1, "halt");
    chk("halt_set", {31'b0, wb_halt}, 32'd1);
    idle_inputs();
    em_valid = 1; em_dread = 1; em_alu_out = 32'h100; dmem_ready = 1;
    #1;
    chk("halt_no_req", {31'b0, dmem_ren}, 32'd0);
    chk("halt_no_stall", {31'b0, mem_stall}, 32'd0);
    idle_inputs();
    step(2, "halt_idle");
    chk("halt_sticky", {31'b0, wb_halt}, 32'd1);

    chk("sb_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
